// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART register port arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } arb_state_t;

  // Requester index: 0 = r0 (CPU core), 1 = r1 (debug/loader).
  typedef logic req_idx_t;

  localparam logic [1:0] TX_DATA_ADDR  = 2'd0;
  localparam logic [1:0] RX_DATA_ADDR  = 2'd1;
  localparam logic [1:0] FREQ_DIV_ADDR = 2'd2;

endpackage

// File: rtl/uart_arb_rr.sv
// Combinational 2-way round-robin pick: a lone requester always wins,
// on contention the requester that was not served last wins.
module uart_arb_rr
  import uart_arb_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t last_grant,
  output logic     grant_valid,
  output req_idx_t grant_idx
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/uart_wb_arbiter.sv
// Shares one UART register port between two stb/ack/err requesters and
// sequences the UART's level handshake (stb, wb_clk phase, ack rise/fall).
module uart_wb_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_stb,
  input  logic       r0_we,
  input  logic [1:0] r0_addr,
  input  logic [7:0] r0_wdata,
  output logic [7:0] r0_rdata,
  output logic       r0_ack,
  output logic       r0_err,
  input  logic       r1_stb,
  input  logic       r1_we,
  input  logic [1:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic [7:0] r1_rdata,
  output logic       r1_ack,
  output logic       r1_err,
  output logic       u_stb,
  output logic       u_clk,
  output logic       u_we,
  output logic [1:0] u_addr,
  output logic [7:0] u_wdata,
  input  logic [7:0] u_rdata,
  input  logic       u_ack
);

  arb_state_t      state;
  req_idx_t        last_grant;
  req_idx_t        gnt;
  logic            grant_valid;
  req_idx_t        grant_idx;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            sel_we;
  logic [1:0]      sel_addr;
  logic [7:0]      sel_wdata;

  uart_arb_rr u_rr (
    .req0        (r0_stb),
    .req1        (r1_stb),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Route the winning requester's command fields toward the UART latch.
  always_comb begin
    sel_we    = grant_idx ? r1_we    : r0_we;
    sel_addr  = grant_idx ? r1_addr  : r0_addr;
    sel_wdata = grant_idx ? r1_wdata : r0_wdata;
    to_hit    = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
  end

  // Transaction sequencer; every output is a register of this block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      to_cnt     <= '0;
      u_stb      <= 1'b0;
      u_clk      <= 1'b0;
      u_we       <= 1'b0;
      u_addr     <= 2'd0;
      u_wdata    <= 8'd0;
      r0_rdata   <= 8'd0;
      r1_rdata   <= 8'd0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt     <= grant_idx;
            u_stb   <= 1'b1;
            u_clk   <= 1'b0;
            u_we    <= ~sel_we;   // UART uses 0 = write
            u_addr  <= sel_addr;
            u_wdata <= sel_wdata;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          u_clk  <= 1'b1;
          to_cnt <= '0;
          state  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (u_ack) begin
            if (u_we) begin
              if (gnt) r1_rdata <= u_rdata;
              else     r0_rdata <= u_rdata;
            end
            u_clk  <= 1'b0;
            to_cnt <= '0;
            state  <= ST_RELEASE;
          end else if (to_hit) begin
            u_stb      <= 1'b0;
            u_clk      <= 1'b0;
            r0_err     <= ~gnt;
            r1_err     <= gnt;
            last_grant <= gnt;
            state      <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!u_ack) begin
            u_stb      <= 1'b0;
            r0_ack     <= ~gnt;
            r1_ack     <= gnt;
            last_grant <= gnt;
            state      <= ST_DONE;
          end else if (to_hit) begin
            u_stb      <= 1'b0;
            u_clk      <= 1'b0;
            r0_err     <= ~gnt;
            r1_err     <= gnt;
            last_grant <= gnt;
            state      <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Requests are not sampled here so the served requester can drop stb.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
